load_buffer_tracker: RTL

// - Tracks in-flight loads between the load unit and the data cache (WB or WT); sized from CVA6Cfg.NrLoadBufEntries.
// - Allocates a cache transaction ID per load request and stores the metadata needed to post-process the returned data.
// - Releases the ID when the dcache response arrives; responses may return out of order.
// - On flush, marks in-flight entries killed so their late responses are dropped rather than written back.

---
 rtl/load_buffer_tracker_pkg.sv | 21 ++
 rtl/load_buffer_tracker_lzc.sv | 23 ++
 rtl/load_buffer_tracker.sv | 102 ++++++++++
 3 files changed

// File: rtl/load_buffer_tracker_pkg.sv
// Shared types and sizing for the load buffer tracker: load metadata payload and ID width helper.
package load_buffer_tracker_pkg;

    localparam int unsigned XLEN                = 64;
    localparam int unsigned TRANS_ID_BITS       = 3;
    localparam int unsigned OFFSET_BITS         = $clog2(XLEN / 8);
    localparam int unsigned NR_LOAD_BUF_ENTRIES = 2;

    // Metadata needed to post-process returned load data
    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [OFFSET_BITS-1:0]   offset;
        logic [1:0]               size;
        logic                     sign_ext;
    } ldbuf_meta_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/load_buffer_tracker_lzc.sv
// Trailing-zero counter: index of the lowest set bit, plus a flag when no bit is set.
module load_buffer_tracker_lzc #(
    parameter int unsigned Width    = 2,
    parameter int unsigned CntWidth = 1
) (
    input  logic [Width-1:0]    in_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                empty_o
);

    // Scan downwards so the lowest set bit wins
    always_comb begin
        cnt_o = '0;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o = CntWidth'(i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/load_buffer_tracker.sv
// Tracks in-flight loads between load unit and dcache: allocates transaction IDs,
// holds per-load metadata, frees IDs on out-of-order responses and kills entries on flush.
module load_buffer_tracker
    import load_buffer_tracker_pkg::*;
#(
    parameter int unsigned NrEntries = NR_LOAD_BUF_ENTRIES,
    parameter int unsigned IdWidth   = id_width(NrEntries)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               req_valid_i,
    input  ldbuf_meta_t        req_meta_i,
    output logic               req_ready_o,
    output logic [IdWidth-1:0] req_id_o,
    input  logic               rsp_valid_i,
    input  logic [IdWidth-1:0] rsp_id_i,
    output ldbuf_meta_t        rsp_meta_o,
    output logic               rsp_keep_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [IdWidth:0]   count_o
);

    logic [NrEntries-1:0] valid_q, valid_d;
    logic [NrEntries-1:0] killed_q, killed_d;
    ldbuf_meta_t          meta_q [NrEntries];
    ldbuf_meta_t          meta_d [NrEntries];

    logic [IdWidth-1:0]   free_id;
    logic                 no_free;
    logic                 alloc;
    logic                 rsp_in_range;
    logic                 rsp_hit;

    // Free slot search works on registered valid[], so a slot freed this cycle is not reused yet
    load_buffer_tracker_lzc #(
        .Width    (NrEntries),
        .CntWidth (IdWidth)
    ) u_free_lzc (
        .in_i    (~valid_q),
        .cnt_o   (free_id),
        .empty_o (no_free)
    );

    assign req_ready_o  = !flush_i && !no_free;
    assign req_id_o     = no_free ? '0 : free_id;
    assign alloc        = req_valid_i && req_ready_o;

    assign rsp_in_range = 32'(rsp_id_i) < NrEntries;
    assign rsp_hit      = rsp_valid_i && rsp_in_range && valid_q[rsp_id_i];
    assign rsp_meta_o   = rsp_in_range ? meta_q[rsp_id_i] : '0;
    // A flush in the same cycle also masks writeback of the response arriving with it
    assign rsp_keep_o   = rsp_hit && !killed_q[rsp_id_i] && !flush_i;

    // Per-entry next state: release beats flush-kill; alloc and release never target the same entry
    always_comb begin
        valid_d  = valid_q;
        killed_d = killed_q;
        meta_d   = meta_q;
        for (int unsigned i = 0; i < NrEntries; i++) begin
            if (rsp_hit && (32'(rsp_id_i) == i)) begin
                valid_d[i]  = 1'b0;
                killed_d[i] = 1'b0;
            end else if (alloc && (32'(free_id) == i)) begin
                valid_d[i]  = 1'b1;
                killed_d[i] = 1'b0;
                meta_d[i]   = req_meta_i;
            end else if (flush_i && valid_q[i]) begin
                killed_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            killed_q <= '0;
            meta_q   <= '{default: '0};
        end else begin
            valid_q  <= valid_d;
            killed_q <= killed_d;
            meta_q   <= meta_d;
        end
    end

    // Occupancy from registered valid[]
    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < NrEntries; i++) begin
            count_o = count_o + (IdWidth+1)'(valid_q[i]);
        end
    end

    assign full_o  = (32'(count_o) == NrEntries);
    assign empty_o = (count_o == '0);

    rsp_to_free_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_i |-> rsp_hit)
        else $error("load_buffer_tracker: response for an entry that is not in flight");

endmodule
